// File: rtl/mem_pkg.sv
// Shared types and constants for the MIPS memory-access stage.
package mem_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b011,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_res;
    logic [31:0] pc_to_reg;
    logic [4:0]  addr_reg_dst;
    logic        reg_write;
    logic        mem_to_reg;
    logic        select_addr_reg;
  } mem_wb_t;

  // Unknown type codes behave as word accesses.
  function automatic logic is_misaligned(input logic [2:0] ls_type, input logic [1:0] addr_lo);
    case (ls_type)
      LS_B, LS_BU: is_misaligned = 1'b0;
      LS_H, LS_HU: is_misaligned = addr_lo[0];
      default:     is_misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between the memory-access stage and the data memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 10
);
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [3:0]        o_mem_be;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;
  logic              i_mem_ack;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    input  i_mem_rdata, i_mem_ack
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    output i_mem_rdata, i_mem_ack
  );
endinterface

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for stores and lane extraction/extension for loads.
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  ls_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] byte_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_shift = load_word >> {addr_lo, 3'b000};
  assign byte_sel   = byte_shift[7:0];
  // Halfword selection only looks at addr[1]; addr[0] is handled by the optional misalign check.
  assign half_sel   = addr_lo[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    be        = BE_WORD;
    wdata     = store_data;
    load_data = load_word;
    case (ls_type)
      LS_B, LS_BU: begin
        be        = BE_BYTE0 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = (ls_type == LS_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      end
      LS_H, LS_HU: begin
        be        = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata     = {2{store_data[15:0]}};
        load_data = (ls_type == LS_H) ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      end
      default: begin
        be        = BE_WORD;
        wdata     = store_data;
        load_data = load_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS memory-access stage: req/ack data-memory sequencing and the MEM/WB register.
// Optional build macro MEM_MISALIGN_CHECK_EN suppresses misaligned H/W accesses and flags them.
//
//   state   | meaning
//   ST_IDLE | no transaction outstanding; mem ops launch, other ops pass to MEM/WB
//   ST_BUSY | request held on the bus until ack; MEM/WB receives bubbles meanwhile
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_unit_if.master     mem,
  input  logic [31:0]           i_ALU_res,
  input  logic [31:0]           i_rt_reg,
  input  logic [31:0]           i_pc_to_reg,
  input  logic [4:0]            i_addr_reg_dst,
  input  logic                  is_RegWrite,
  input  logic                  is_MemtoReg,
  input  logic                  is_MemWrite,
  input  logic                  is_MemRead,
  input  logic                  is_select_addr_reg,
  input  logic [2:0]            is_load_store_type,
  output logic                  os_stall,
  output logic [31:0]           o_read_data,
  output logic [31:0]           o_ALU_res,
  output logic [31:0]           o_pc_to_reg,
  output logic [4:0]            o_addr_reg_dst,
  output logic                  os_RegWrite,
  output logic                  os_MemtoReg,
  output logic                  os_select_addr_reg,
  output logic                  os_misaligned
);

  state_e      state_q, state_nxt;
  mem_wb_t     wb_q, wb_nxt, wb_pass;
  logic        mem_op, suppress, launch;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_data_c;

  load_store_align u_align (
    .ls_type    (is_load_store_type),
    .addr_lo    (i_ALU_res[1:0]),
    .store_data (i_rt_reg),
    .load_word  (mem.i_mem_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .load_data  (load_data_c)
  );

  assign mem_op = is_MemRead | is_MemWrite;
`ifdef MEM_MISALIGN_CHECK_EN
  assign suppress = mem_op & is_misaligned(is_load_store_type, i_ALU_res[1:0]);
`else
  assign suppress = 1'b0;
`endif
  assign launch = mem_op & ~suppress;

  assign os_stall = ((state_q == ST_IDLE) & launch) | ((state_q == ST_BUSY) & ~mem.i_mem_ack);

  always_comb begin
    wb_pass                 = '0;
    wb_pass.alu_res         = i_ALU_res;
    wb_pass.pc_to_reg       = i_pc_to_reg;
    wb_pass.addr_reg_dst    = i_addr_reg_dst;
    wb_pass.reg_write       = is_RegWrite;
    wb_pass.mem_to_reg      = is_MemtoReg;
    wb_pass.select_addr_reg = is_select_addr_reg;
  end

  always_comb begin
    state_nxt = state_q;
    wb_nxt    = '0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_nxt = ST_BUSY;
        end else if (!suppress) begin
          wb_nxt = wb_pass;
        end
      end
      ST_BUSY: begin
        if (mem.i_mem_ack) begin
          state_nxt        = ST_IDLE;
          wb_nxt           = wb_pass;
          wb_nxt.read_data = load_data_c;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      wb_q            <= '0;
      mem.o_mem_we    <= 1'b0;
      mem.o_mem_addr  <= '0;
      mem.o_mem_be    <= '0;
      mem.o_mem_wdata <= '0;
    end else begin
      state_q <= state_nxt;
      wb_q    <= wb_nxt;
      if (state_q == ST_IDLE && launch) begin
        mem.o_mem_we    <= is_MemWrite;
        mem.o_mem_addr  <= i_ALU_res[ADDR_W+1:2];
        mem.o_mem_be    <= be_c;
        mem.o_mem_wdata <= wdata_c;
      end
    end
  end

  assign mem.o_mem_req = (state_q == ST_BUSY);

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misaligned_q <= 1'b0;
    else      misaligned_q <= (state_q == ST_IDLE) & suppress;
  end
  assign os_misaligned = misaligned_q;
`else
  assign os_misaligned = 1'b0;
`endif

  assign o_read_data        = wb_q.read_data;
  assign o_ALU_res          = wb_q.alu_res;
  assign o_pc_to_reg        = wb_q.pc_to_reg;
  assign o_addr_reg_dst     = wb_q.addr_reg_dst;
  assign os_RegWrite        = wb_q.reg_write;
  assign os_MemtoReg        = wb_q.mem_to_reg;
  assign os_select_addr_reg = wb_q.select_addr_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural memory/load-store reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_ALU_res = '0, i_rt_reg = '0, i_pc_to_reg = '0;
  logic [4:0]  i_addr_reg_dst = '0;
  logic        is_RegWrite = 0, is_MemtoReg = 0, is_MemWrite = 0, is_MemRead = 0, is_select_addr_reg = 0;
  logic [2:0]  is_load_store_type = '0;
  logic        os_stall, os_RegWrite, os_MemtoReg, os_select_addr_reg, os_misaligned;
  logic [31:0] o_read_data, o_ALU_res, o_pc_to_reg;
  logic [4:0]  o_addr_reg_dst;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cycles, req_cycles;

  mem_access_unit_if #(.ADDR_W(10)) bus ();

  mem_access_unit #(.ADDR_W(10)) dut (
    .clk                (clk),
    .rst                (rst_n),
    .mem                (bus),
    .i_ALU_res          (i_ALU_res),
    .i_rt_reg           (i_rt_reg),
    .i_pc_to_reg        (i_pc_to_reg),
    .i_addr_reg_dst     (i_addr_reg_dst),
    .is_RegWrite        (is_RegWrite),
    .is_MemtoReg        (is_MemtoReg),
    .is_MemWrite        (is_MemWrite),
    .is_MemRead         (is_MemRead),
    .is_select_addr_reg (is_select_addr_reg),
    .is_load_store_type (is_load_store_type),
    .os_stall           (os_stall),
    .o_read_data        (o_read_data),
    .o_ALU_res          (o_ALU_res),
    .o_pc_to_reg        (o_pc_to_reg),
    .o_addr_reg_dst     (o_addr_reg_dst),
    .os_RegWrite        (os_RegWrite),
    .os_MemtoReg        (os_MemtoReg),
    .os_select_addr_reg (os_select_addr_reg),
    .os_misaligned      (os_misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
  end

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] t);
    if (t == 3'd0 || t == 3'd4) return 1;
    if (t == 3'd1 || t == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic ref_supp(input logic [2:0] t, input logic [1:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
    return (a % size_of(t)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] t, input logic [1:0] a);
    int off;
    if (size_of(t) == 1) return 4'(1 << a);
    if (size_of(t) == 2) begin
      off = (a / 2) * 2;
      return 4'(3 << off);
    end
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] t, input logic [31:0] rt);
    if (size_of(t) == 1) return (rt & 32'hFF) * 32'h0101_0101;
    if (size_of(t) == 2) return (rt & 32'hFFFF) * 32'h0001_0001;
    return rt;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] v;
    logic sgn;
    sgn = (t == 3'd0 || t == 3'd1);
    if (size_of(t) == 1) begin
      v = (w >> (8 * a)) & 32'hFF;
      if (sgn && v >= 32'h80) v = v - 32'h100;
      return v;
    end
    if (size_of(t) == 2) begin
      v = (w >> (16 * (a / 2))) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v - 32'h1_0000;
      return v;
    end
    return w;
  endfunction

  // ---------------- scenario driver ----------------
  // Called #1 after a rising edge; returns #1 after the edge where MEM/WB shows the result.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] rt, input logic [31:0] pc,
                        input logic [4:0] rd, input logic regw, input logic m2r,
                        input logic mw, input logic mr, input logic sel,
                        input logic [2:0] lst, input int dly, input logic [31:0] rdat);
    logic mem, supp, go;
    logic [31:0] exp_rd;
    i_ALU_res = alu; i_rt_reg = rt; i_pc_to_reg = pc; i_addr_reg_dst = rd;
    is_RegWrite = regw; is_MemtoReg = m2r; is_MemWrite = mw; is_MemRead = mr;
    is_select_addr_reg = sel; is_load_store_type = lst;
    bus.i_mem_ack = 1'b0; bus.i_mem_rdata = $urandom;
    mem = mw | mr; supp = mem && ref_supp(lst, alu[1:0]); go = mem && !supp;
    stall_cycles = 0; req_cycles = 0;
    #3;
    if (os_stall === 1'b1) stall_cycles++;
    n_checks++;
    if (os_stall !== go) begin n_fail++; $display("FAIL stall_c0: got %b expected %b", os_stall, go); end
    n_checks++;
    if (bus.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL req_c0: got %b expected 0", bus.o_mem_req); end
    @(posedge clk); #1;
    exp_rd = 32'd0;
    if (go) begin
      for (int c = 1; c <= dly; c++) begin
        if (c == dly) begin bus.i_mem_ack = 1'b1; bus.i_mem_rdata = rdat; end
        #1;
        if (os_stall === 1'b1) stall_cycles++;
        if (bus.o_mem_req === 1'b1) req_cycles++;
        n_checks++;
        if (bus.o_mem_req !== 1'b1) begin n_fail++; $display("FAIL req_busy: got %b expected 1", bus.o_mem_req); end
        n_checks++;
        if (bus.o_mem_we !== mw) begin n_fail++; $display("FAIL we: got %b expected %b", bus.o_mem_we, mw); end
        n_checks++;
        if (bus.o_mem_addr !== alu[11:2]) begin n_fail++; $display("FAIL addr: got %h expected %h", bus.o_mem_addr, alu[11:2]); end
        n_checks++;
        if (bus.o_mem_be !== ref_be(lst, alu[1:0])) begin n_fail++; $display("FAIL be: got %b expected %b", bus.o_mem_be, ref_be(lst, alu[1:0])); end
        n_checks++;
        if (bus.o_mem_wdata !== ref_wdata(lst, rt)) begin n_fail++; $display("FAIL wdata: got %h expected %h", bus.o_mem_wdata, ref_wdata(lst, rt)); end
        n_checks++;
        if (os_stall !== (c != dly)) begin n_fail++; $display("FAIL stall_busy c%0d: got %b expected %b", c, os_stall, c != dly); end
        n_checks++;
        if ({os_RegWrite, os_MemtoReg, os_select_addr_reg, o_ALU_res, o_read_data} !== '0) begin
          n_fail++; $display("FAIL bubble c%0d: got regw=%b alu=%h rd=%h expected zeros", c, os_RegWrite, o_ALU_res, o_read_data);
        end
        @(posedge clk); #1;
        bus.i_mem_ack = 1'b0;
      end
      exp_rd = ref_load(lst, alu[1:0], rdat);
    end
    n_checks++;
    if (o_ALU_res !== (supp ? 32'd0 : alu)) begin n_fail++; $display("FAIL wb_alu: got %h expected %h", o_ALU_res, supp ? 32'd0 : alu); end
    n_checks++;
    if (o_pc_to_reg !== (supp ? 32'd0 : pc)) begin n_fail++; $display("FAIL wb_pc: got %h expected %h", o_pc_to_reg, supp ? 32'd0 : pc); end
    n_checks++;
    if (o_addr_reg_dst !== (supp ? 5'd0 : rd)) begin n_fail++; $display("FAIL wb_rd: got %0d expected %0d", o_addr_reg_dst, supp ? 5'd0 : rd); end
    n_checks++;
    if ({os_RegWrite, os_MemtoReg, os_select_addr_reg} !== (supp ? 3'b000 : {regw, m2r, sel})) begin
      n_fail++; $display("FAIL wb_ctl: got %b%b%b expected %b", os_RegWrite, os_MemtoReg, os_select_addr_reg, supp ? 3'b000 : {regw, m2r, sel});
    end
    n_checks++;
    if (o_read_data !== exp_rd) begin n_fail++; $display("FAIL wb_read_data: got %h expected %h", o_read_data, exp_rd); end
    n_checks++;
    if (os_misaligned !== supp) begin n_fail++; $display("FAIL misaligned: got %b expected %b", os_misaligned, supp); end
    n_checks++;
    if (bus.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL req_after: got %b expected 0", bus.o_mem_req); end
  endtask

  task automatic idle_cycle();
    {is_RegWrite, is_MemtoReg, is_MemWrite, is_MemRead, is_select_addr_reg} = '0;
    i_ALU_res = '0; i_pc_to_reg = '0; i_addr_reg_dst = '0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({o_read_data, o_ALU_res, o_pc_to_reg, o_addr_reg_dst, os_RegWrite, os_MemtoReg, os_select_addr_reg, os_misaligned} !== '0) begin
      n_fail++; $display("FAIL reset_wb: got alu=%h rd=%h regw=%b expected zeros", o_ALU_res, o_read_data, os_RegWrite);
    end
    n_checks++;
    if ({bus.o_mem_req, os_stall} !== 2'b00) begin n_fail++; $display("FAIL reset_req: got req=%b stall=%b expected 00", bus.o_mem_req, os_stall); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    run_op(32'h0000_0042, 32'h0, 32'h0000_1000, 5'd5, 1, 0, 0, 0, 0, 3'b011, 1, 32'h0);
    n_checks++;
    if (o_ALU_res !== 32'h42 || o_addr_reg_dst !== 5'd5 || os_RegWrite !== 1'b1) begin
      n_fail++; $display("FAIL add_pass: got alu=%h rd=%0d regw=%b expected 42/5/1", o_ALU_res, o_addr_reg_dst, os_RegWrite);
    end
    n_checks++;
    if (stall_cycles !== 0) begin n_fail++; $display("FAIL add_stall: got %0d expected 0", stall_cycles); end
  endtask

  task automatic test_store_sb();
    i_rt_reg = 32'h1234_56AB;
    run_op(32'h0000_0007, 32'h1234_56AB, 32'h0, 5'd0, 0, 0, 1, 0, 0, 3'b000, 3, 32'h0);
    n_checks++;
    if (stall_cycles !== 3) begin n_fail++; $display("FAIL sb_stall_cycles: got %0d expected 3", stall_cycles); end
    n_checks++;
    if (os_RegWrite !== 1'b0) begin n_fail++; $display("FAIL sb_regwrite: got %b expected 0", os_RegWrite); end
    n_checks++;
    if (bus.o_mem_be !== 4'b1000 || bus.o_mem_wdata !== 32'hABAB_ABAB || bus.o_mem_addr !== 10'd1) begin
      n_fail++; $display("FAIL sb_bus: got be=%b wdata=%h addr=%0d expected 1000/ababab ab/1", bus.o_mem_be, bus.o_mem_wdata, bus.o_mem_addr);
    end
  endtask

  task automatic test_loads();
    run_op(32'h2, 32'h0, 32'h0, 5'd8, 1, 1, 0, 1, 0, 3'b000, 1, 32'h0080_0000);
    n_checks++;
    if (o_read_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb: got %h expected ffffff80", o_read_data); end
    run_op(32'h2, 32'h0, 32'h0, 5'd8, 1, 1, 0, 1, 0, 3'b100, 2, 32'h0080_0000);
    n_checks++;
    if (o_read_data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu: got %h expected 00000080", o_read_data); end
    run_op(32'h2, 32'h0, 32'h0, 5'd9, 1, 1, 0, 1, 0, 3'b001, 1, 32'h8001_0000);
    n_checks++;
    if (o_read_data !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh: got %h expected ffff8001", o_read_data); end
    run_op(32'h0, 32'h0, 32'h0, 5'd9, 1, 1, 0, 1, 0, 3'b101, 1, 32'h8001_F00D);
    n_checks++;
    if (o_read_data !== 32'h0000_F00D) begin n_fail++; $display("FAIL lhu: got %h expected 0000f00d", o_read_data); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int reqs;
    run_op(32'h0000_0010, 32'h0, 32'h0, 5'd3, 1, 1, 0, 1, 0, 3'b011, 1, 32'hCAFE_0001);
    reqs = req_cycles;
    n_checks++;
    if (stall_cycles !== 1) begin n_fail++; $display("FAIL b2b_stall1: got %0d expected 1", stall_cycles); end
    run_op(32'h0000_0014, 32'h0, 32'h0, 5'd4, 1, 1, 0, 1, 0, 3'b011, 1, 32'hCAFE_0002);
    reqs += req_cycles;
    n_checks++;
    if (stall_cycles !== 1) begin n_fail++; $display("FAIL b2b_stall2: got %0d expected 1", stall_cycles); end
    n_checks++;
    if (reqs !== 2) begin n_fail++; $display("FAIL b2b_requests: got %0d expected 2", reqs); end
    idle_cycle();
  endtask

  task automatic test_reset_mid_busy();
    i_ALU_res = 32'h0000_0020; i_addr_reg_dst = 5'd7; is_RegWrite = 1; is_MemRead = 1;
    is_load_store_type = 3'b011;
    @(posedge clk); #1;
    n_checks++;
    if (bus.o_mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre: got %b expected 1", bus.o_mem_req); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_busy_req: got %b expected 0", bus.o_mem_req); end
    idle_cycle();
    bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.o_mem_req, os_RegWrite, o_read_data, o_addr_reg_dst} !== '0) begin
      n_fail++; $display("FAIL rst_late_ack: got req=%b regw=%b rd=%h dst=%0d expected zeros", bus.o_mem_req, os_RegWrite, o_read_data, o_addr_reg_dst);
    end
    bus.i_mem_ack = 1'b0;
  endtask

`ifdef MEM_MISALIGN_CHECK_EN
  task automatic test_misaligned();
    run_op(32'h0000_0002, 32'h0, 32'h0, 5'd6, 1, 1, 0, 1, 0, 3'b011, 1, 32'h0);
    n_checks++;
    if (stall_cycles !== 0 || os_RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL mis_lw: got stall=%0d regw=%b expected 0/0", stall_cycles, os_RegWrite);
    end
    idle_cycle();
    n_checks++;
    if (os_misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b expected 0", os_misaligned); end
  endtask
`endif

  task automatic test_random();
    logic [2:0] types [8];
    logic [2:0] t;
    logic [1:0] kind;
    types = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd2, 3'd6, 3'd7};
    for (int i = 0; i < 60; i++) begin
      t = types[$urandom_range(7, 0)];
      kind = 2'($urandom_range(3, 0));
      run_op($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
             kind[1], kind[0], 1'($urandom), t, $urandom_range(4, 1), $urandom);
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_store_sb();
    test_loads();
    test_back_to_back();
`ifdef MEM_MISALIGN_CHECK_EN
    test_misaligned();
`endif
    test_random();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
